srl_fifo: RTL and testbench

SRL_FIFO -- requirements
Module: srl_fifo

---
 rtl/srl_fifo.sv | 74 +++++++
 tb/tb_srl_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/srl_fifo.sv
// Shift-register FIFO with first-word fall-through output. Storage has no reset
// so it can map onto SRL primitives; only the occupancy counter and flags are reset.
module srl_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] d,
  input  logic             rd,
  output logic [WIDTH-1:0] y,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             unf
);

  // Handshake: a write is taken when wr=1 and the FIFO is not full or a read is
  // taken on the same edge; a read is taken when rd=1 and the FIFO is not empty.
  // Neither is taken while clr=1 or on the first edge after reset release.

  logic [WIDTH-1:0] mem [DEPTH];
  logic             armed;
  logic             wr_ok;
  logic             rd_ok;
  logic [AW:0]      cnt_m1;
  logic [AW-1:0]    ra;

  always_comb begin
    empty  = (count == '0);
    full   = (count == (AW+1)'(DEPTH));
    wr_ok  = armed & ~clr & wr & (~full | rd);
    rd_ok  = armed & ~clr & rd & ~empty;
    cnt_m1 = count - (AW+1)'(1);
    ra     = cnt_m1[AW-1:0];
    y      = empty ? '0 : mem[ra];
  end

  // Newest word enters stage 0; the oldest sits at stage count-1.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[0] <= d;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      armed <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wr && full && !rd) ovf <= 1'b1;
      if (rd && empty)       unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_srl_fifo.sv
// Bench for srl_fifo: reset/table vectors, hand-written corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_srl_fifo;

  localparam int W = 16;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] y;
  logic         empty, full, ovf, unf;
  logic [4:0]   count;

  int vectors = 0;
  int miscompares = 0;

  srl_fifo #(.WIDTH(W), .DEPTH(N)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .d(d), .rd(rd),
    .y(y), .empty(empty), .full(full), .count(count), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Reference model: plain queue, oldest at the front.
  logic [W-1:0] exp_q[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic         m_armed = 1'b0;

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_armed = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic w, input logic r, input logic [W-1:0] dd);
    bit is_full, is_empty, w_ok, r_ok;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (c) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      is_full  = (exp_q.size() == N);
      is_empty = (exp_q.size() == 0);
      w_ok = w && (!is_full || r);
      r_ok = r && !is_empty;
      if (w && is_full && !r) m_ovf = 1'b1;
      if (r && is_empty) m_unf = 1'b1;
      if (r_ok) void'(exp_q.pop_front());
      if (w_ok) exp_q.push_back(dd);
    end
  endtask

  task automatic check(input string name, input int ec, input logic [W-1:0] ey,
                       input logic eo, input logic eu);
    vectors++;
    if (count !== 5'(ec) || y !== ey || empty !== (ec == 0) || full !== (ec == N) ||
        ovf !== eo || unf !== eu) begin
      miscompares++;
      $display("FAIL %s: got count=%0d y=%h empty=%b full=%b ovf=%b unf=%b, want count=%0d y=%h empty=%b full=%b ovf=%b unf=%b",
               name, count, y, empty, full, ovf, unf, ec, ey, (ec == 0), (ec == N), eo, eu);
    end
  endtask

  task automatic check_model(input string name);
    logic [W-1:0] ey;
    ey = (exp_q.size() > 0) ? exp_q[0] : '0;
    check(name, exp_q.size(), ey, m_ovf, m_unf);
  endtask

  // Driver: inputs change 1 time unit after an edge, outputs sampled likewise.
  task automatic step(input logic c, input logic w, input logic r, input logic [W-1:0] dd);
    clr = c; wr = w; rd = r; d = dd;
    @(posedge clk);
    #1;
    model_step(c, w, r, dd);
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  // Reset asserted between edges, checked before any edge, released mid-cycle.
  task automatic do_reset(input string name);
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check(name, 0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic         c, w, r;
    logic [W-1:0] dd;
    int           ec;
    logic [W-1:0] ey;
    logic         eo, eu;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'h000A, 1, 16'h000A, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'h000B, 2, 16'h000A, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h000C, 3, 16'h000A, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h000D, 3, 16'h000B, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 2, 16'h000C, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1, 16'h000D, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 1, 16'h1234, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h5555, 0, 16'h0000, 1'b0, 1'b0};

    model_reset();
    #3 check("reset_initial", 0, '0, 1'b0, 1'b0);
    #4 rst_n = 1'b1;

    // First edge after release must ignore the write.
    step(1'b0, 1'b1, 1'b0, 16'hBEEF);
    check("first_edge_ignored", 0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].dd);
      check($sformatf("table_%0d", i), tbl[i].ec, tbl[i].ey, tbl[i].eo, tbl[i].eu);
    end

    do_reset("reset_pulse");
    step(1'b0, 1'b0, 1'b0, '0);

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= N; i++) step(1'b0, 1'b1, 1'b0, W'(i));
    check("fill_full", N, 16'h0001, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'hFFFF);
    check("overflow", N, 16'h0001, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check($sformatf("drain_%0d", k), N-1-k, (k < N-1) ? W'(k+2) : '0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, '0);
    check("underflow", 0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0);
    check("clr_flags", 0, '0, 1'b0, 1'b0);

    // Simultaneous write and read while full keeps count and order.
    for (int i = 1; i <= N; i++) step(1'b0, 1'b1, 1'b0, W'(i));
    step(1'b0, 1'b1, 1'b1, 16'h0011);
    check("wr_rd_full", N, 16'h0002, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      check($sformatf("drain2_%0d", k), N-1-k, (k < N-1) ? W'(k+3) : '0, 1'b0, 1'b0);
    end

    // Flush with a concurrent write at count 5.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, W'(16'h0100 + i));
    check("five_held", 5, 16'h0100, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h7777);
    check("flush_with_write", 0, '0, 1'b0, 1'b0);

    // Asynchronous reset at count 7.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, W'(16'h0200 + i));
    check("seven_held", 7, 16'h0200, 1'b0, 1'b0);
    do_reset("reset_mid_op");
    step(1'b0, 1'b1, 1'b1, 16'hAAAA);
    check("post_reset_first_edge", 0, '0, 1'b0, 1'b0);

    // Randomized traffic with phases biased toward full and toward empty.
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 80 : 25;
      rp = (ph % 2 == 0) ? 25 : 80;
      for (int n = 0; n < 400; n++) begin
        logic c, w, r;
        c = ($urandom_range(0, 199) == 0);
        w = ($urandom_range(0, 99) < wp);
        r = ($urandom_range(0, 99) < rp);
        step(c, w, r, W'($urandom));
        check_model($sformatf("rand_%0d_%0d", ph, n));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
